// File: rtl/xgbe_mac_rx_pkt_fifo.sv
// Store-and-forward RX packet buffer: commits only complete good frames, drops bad/overflowing ones.
// Optional per-reason frame counters are enabled by defining XGBE_RX_FIFO_STATS_EN.
module xgbe_mac_rx_pkt_fifo #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        xgemac_clk_156,
    input  logic        xgbe_mac_resetn,
    input  logic [63:0] mac_rx_tdata,
    input  logic [7:0]  mac_rx_tkeep,
    input  logic        mac_rx_tlast,
    input  logic        mac_rx_tvalid,
    input  logic        mac_rx_tuser,
    output logic [63:0] rx_fifo_tdata,
    output logic [7:0]  rx_fifo_tkeep,
    output logic        rx_fifo_tlast,
    output logic        rx_fifo_tvalid,
    input  logic        rx_fifo_tready,
    output logic        rx_pkt_drop
`ifdef XGBE_RX_FIFO_STATS_EN
    ,
    output logic [31:0] rx_good_pkt_cnt,
    output logic [31:0] rx_bad_pkt_cnt,
    output logic [31:0] rx_ovf_pkt_cnt
`endif
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_DROP} wr_state_t;

    wr_state_t     wr_state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_commit;
    logic [PW-1:0] rd_ptr;
    logic [72:0]   mem [0:(1<<DEPTH_LOG2)-1];
    logic [72:0]   ram_q;
    logic          ram_vld;

    logic full;
    logic readable;
    logic wr_en;
    logic bad_ev;
    logic ovf_ev;
    logic load_out;
    logic pop;

    assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign readable = (wr_commit != rd_ptr);
    assign wr_en    = mac_rx_tvalid && (wr_state != WR_DROP) && !full;
    assign bad_ev   = wr_en && mac_rx_tlast && !mac_rx_tuser;
    assign ovf_ev   = mac_rx_tvalid && mac_rx_tlast && ((wr_state == WR_DROP) || full);

    // Write side: beats land past wr_commit and only become visible on a good tlast.
    always_ff @(posedge xgemac_clk_156) begin
        if (!xgbe_mac_resetn) begin
            wr_state    <= WR_IDLE;
            wr_ptr      <= '0;
            wr_commit   <= '0;
            rx_pkt_drop <= 1'b0;
        end else begin
            rx_pkt_drop <= bad_ev || ovf_ev;
            if (mac_rx_tvalid) begin
                case (wr_state)
                    WR_IDLE, WR_ACTIVE: begin
                        if (!full) begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                            if (!mac_rx_tlast) begin
                                wr_state <= WR_ACTIVE;
                            end else if (mac_rx_tuser) begin
                                wr_commit <= wr_ptr + PTR_ONE;
                                wr_state  <= WR_IDLE;
                            end else begin
                                wr_ptr   <= wr_commit;
                                wr_state <= WR_IDLE;
                            end
                        end else begin
                            wr_ptr   <= wr_commit;
                            wr_state <= mac_rx_tlast ? WR_IDLE : WR_DROP;
                        end
                    end
                    WR_DROP: begin
                        wr_ptr <= wr_commit;
                        if (mac_rx_tlast) wr_state <= WR_IDLE;
                    end
                    default: wr_state <= WR_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge xgemac_clk_156) begin
        if (wr_en) mem[wr_ptr[PW-2:0]] <= {mac_rx_tlast, mac_rx_tkeep, mac_rx_tdata};
    end

    // Read side: RAM output stage plus output register form a two-entry pipe,
    // so a beat is popped whenever the RAM stage is empty or is moving forward.
    assign load_out = ram_vld && (!rx_fifo_tvalid || rx_fifo_tready);
    assign pop      = readable && (!ram_vld || load_out);

    always_ff @(posedge xgemac_clk_156) begin
        if (pop) ram_q <= mem[rd_ptr[PW-2:0]];
    end

    always_ff @(posedge xgemac_clk_156) begin
        if (!xgbe_mac_resetn) begin
            rd_ptr         <= '0;
            ram_vld        <= 1'b0;
            rx_fifo_tvalid <= 1'b0;
            rx_fifo_tdata  <= '0;
            rx_fifo_tkeep  <= '0;
            rx_fifo_tlast  <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                ram_vld <= 1'b1;
            end else if (load_out) begin
                ram_vld <= 1'b0;
            end
            if (load_out) begin
                rx_fifo_tvalid <= 1'b1;
                rx_fifo_tdata  <= ram_q[63:0];
                rx_fifo_tkeep  <= ram_q[71:64];
                rx_fifo_tlast  <= ram_q[72];
            end else if (rx_fifo_tready) begin
                rx_fifo_tvalid <= 1'b0;
            end
        end
    end

`ifdef XGBE_RX_FIFO_STATS_EN
    logic commit_ev;
    assign commit_ev = wr_en && mac_rx_tlast && mac_rx_tuser;

    always_ff @(posedge xgemac_clk_156) begin
        if (!xgbe_mac_resetn) begin
            rx_good_pkt_cnt <= '0;
            rx_bad_pkt_cnt  <= '0;
            rx_ovf_pkt_cnt  <= '0;
        end else begin
            if (commit_ev && (rx_good_pkt_cnt != 32'hFFFF_FFFF)) rx_good_pkt_cnt <= rx_good_pkt_cnt + 32'd1;
            if (bad_ev && (rx_bad_pkt_cnt != 32'hFFFF_FFFF))     rx_bad_pkt_cnt  <= rx_bad_pkt_cnt + 32'd1;
            if (ovf_ev && (rx_ovf_pkt_cnt != 32'hFFFF_FFFF))     rx_ovf_pkt_cnt  <= rx_ovf_pkt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xgbe_mac_rx_pkt_fifo.sv
// Directed bench for xgbe_mac_rx_pkt_fifo: a queue of expected good-frame beats is compared every cycle.
module tb_xgbe_mac_rx_pkt_fifo;
    localparam int DL2 = 4;
    localparam int CAP = 1 << DL2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [63:0] mac_rx_tdata = '0;
    logic [7:0]  mac_rx_tkeep = '0;
    logic        mac_rx_tlast = 1'b0;
    logic        mac_rx_tvalid = 1'b0;
    logic        mac_rx_tuser = 1'b0;
    logic [63:0] rx_fifo_tdata;
    logic [7:0]  rx_fifo_tkeep;
    logic        rx_fifo_tlast;
    logic        rx_fifo_tvalid;
    logic        rx_fifo_tready = 1'b0;
    logic        rx_pkt_drop;
`ifdef XGBE_RX_FIFO_STATS_EN
    logic [31:0] rx_good_pkt_cnt, rx_bad_pkt_cnt, rx_ovf_pkt_cnt;
`endif

    always #5 clk = ~clk;

    xgbe_mac_rx_pkt_fifo #(.DEPTH_LOG2(DL2)) dut (
        .xgemac_clk_156 (clk),
        .xgbe_mac_resetn(resetn),
        .mac_rx_tdata   (mac_rx_tdata),
        .mac_rx_tkeep   (mac_rx_tkeep),
        .mac_rx_tlast   (mac_rx_tlast),
        .mac_rx_tvalid  (mac_rx_tvalid),
        .mac_rx_tuser   (mac_rx_tuser),
        .rx_fifo_tdata  (rx_fifo_tdata),
        .rx_fifo_tkeep  (rx_fifo_tkeep),
        .rx_fifo_tlast  (rx_fifo_tlast),
        .rx_fifo_tvalid (rx_fifo_tvalid),
        .rx_fifo_tready (rx_fifo_tready),
        .rx_pkt_drop    (rx_pkt_drop)
`ifdef XGBE_RX_FIFO_STATS_EN
        ,
        .rx_good_pkt_cnt(rx_good_pkt_cnt),
        .rx_bad_pkt_cnt (rx_bad_pkt_cnt),
        .rx_ovf_pkt_cnt (rx_ovf_pkt_cnt)
`endif
    );

    logic [72:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          drop_seen = 0;
    int          out_cnt = 0;
    bit          chk_en = 1'b0;
    bit          rand_rdy = 1'b0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [72:0] prev_d = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: every committed good frame is pushed beat by beat; output must replay it in order.
    always @(negedge clk) begin
        logic [72:0] cur;
        logic [72:0] e;
        cur = {rx_fifo_tlast, rx_fifo_tkeep, rx_fifo_tdata};
        if (!chk_en) begin
            prev_v = 1'b0;
        end else begin
            if (rx_pkt_drop) drop_seen++;
            if (prev_v && !prev_r) begin
                checks++;
                if (!rx_fifo_tvalid || cur !== prev_d) begin
                    errors++;
                    $display("FAIL hold actual=%0b/%0h required=1/%0h", rx_fifo_tvalid, cur, prev_d);
                end
            end
            if (rx_fifo_tvalid && rx_fifo_tready) begin
                checks++;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat actual=%0h required=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL beat actual=%0h required=%0h", cur, e);
                    end
                end
            end
            prev_v = rx_fifo_tvalid;
            prev_r = rx_fifo_tready;
            prev_d = cur;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) rx_fifo_tready = ($urandom_range(0, 1) == 1);
    end

    task automatic send_frame(input int len, input logic [63:0] base, input logic [7:0] last_keep,
                              input bit user, input bit expect_out);
        logic       last;
        logic [7:0] k;
        for (int i = 0; i < len; i++) begin
            last = (i == len - 1);
            k    = last ? last_keep : 8'hFF;
            if (expect_out) exp_q.push_back({last, k, base + 64'(i)});
            mac_rx_tvalid = 1'b1;
            mac_rx_tdata  = base + 64'(i);
            mac_rx_tkeep  = k;
            mac_rx_tlast  = last;
            mac_rx_tuser  = last ? user : 1'b0;
            cyc(1);
        end
        mac_rx_tvalid = 1'b0;
        mac_rx_tlast  = 1'b0;
        mac_rx_tuser  = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            cyc(1);
            t++;
        end
        cyc(4);
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0, o0, t, len, exp_drops;

        // Reset state
        cyc(3);
        @(negedge clk);
        chk("rst_tvalid", 64'(rx_fifo_tvalid), 64'd0);
        chk("rst_tdata", rx_fifo_tdata, 64'd0);
        chk("rst_tkeep", 64'(rx_fifo_tkeep), 64'd0);
        chk("rst_tlast", 64'(rx_fifo_tlast), 64'd0);
        chk("rst_drop", 64'(rx_pkt_drop), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk_en = 1'b1;
        cyc(2);

        // Good 8-beat frame and first-beat latency
        rx_fifo_tready = 1'b1;
        send_frame(8, 64'h1, 8'h0F, 1'b1, 1'b1);
        @(negedge clk);
        chk("lat_0", 64'(rx_fifo_tvalid), 64'd0);
        @(negedge clk);
        chk("lat_1", 64'(rx_fifo_tvalid), 64'd0);
        @(negedge clk);
        chk("lat_2", 64'(rx_fifo_tvalid), 64'd1);
        chk("first_tdata", rx_fifo_tdata, 64'h1);
        chk("first_tkeep", 64'(rx_fifo_tkeep), 64'hFF);
        @(posedge clk);
        #1;
        drain("good_drain");
        chk("good_beats", 64'(out_cnt), 64'd8);
        chk("good_nodrop", 64'(drop_seen), 64'd0);

        // Bad frame, then a good one
        d0 = drop_seen;
        o0 = out_cnt;
        send_frame(6, 64'h600, 8'h3F, 1'b0, 1'b0);
        cyc(5);
        chk("bad_drop", 64'(drop_seen - d0), 64'd1);
        chk("bad_nobeats", 64'(out_cnt - o0), 64'd0);
        send_frame(3, 64'h700, 8'h07, 1'b1, 1'b1);
        drain("bad_next");

        // Overflow with tready low
        rx_fifo_tready = 1'b0;
        d0 = drop_seen;
        o0 = out_cnt;
        send_frame(10, 64'hA00, 8'hFF, 1'b1, 1'b1);
        send_frame(10, 64'hB00, 8'hFF, 1'b1, 1'b0);
        cyc(4);
        chk("ovf_drop", 64'(drop_seen - d0), 64'd1);
        chk("ovf_stall", 64'(out_cnt - o0), 64'd0);
        rx_fifo_tready = 1'b1;
        drain("ovf_drain_a");
        chk("ovf_a_beats", 64'(out_cnt - o0), 64'd10);
        send_frame(10, 64'hC00, 8'hFF, 1'b1, 1'b1);
        drain("ovf_drain_c");
        chk("ovf_c_beats", 64'(out_cnt - o0), 64'd20);
        chk("ovf_drop_end", 64'(drop_seen - d0), 64'd1);

        // Back-to-back single-beat frames
        fork
            begin
                for (int i = 0; i < 12; i++) send_frame(1, 64'hB000 + 64'(i), 8'h01, 1'b1, 1'b1);
            end
            begin
                t = 0;
                @(negedge clk);
                while (!rx_fifo_tvalid && t < 10) begin
                    @(negedge clk);
                    t++;
                end
                chk("b2b_start", 64'(rx_fifo_tvalid), 64'd1);
                for (int j = 1; j < 12; j++) begin
                    @(negedge clk);
                    chk("b2b_cont", 64'(rx_fifo_tvalid), 64'd1);
                end
            end
        join
        cyc(1);
        drain("b2b_drain");

        // Random backpressure, frames crossing the pointer wrap; oversize frames must drop
        d0 = drop_seen;
        exp_drops = 0;
        rand_rdy = 1'b1;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 24);
            if (len > CAP) begin
                exp_drops++;
                send_frame(len, 64'(f) << 32, 8'h01, 1'b1, 1'b0);
            end else begin
                t = 0;
                while (exp_q.size() + len > CAP && t < 1000) begin
                    cyc(1);
                    t++;
                end
                if (t >= 1000) chk("rnd_space", 64'(exp_q.size()), 64'd0);
                send_frame(len, 64'(f) << 32, 8'(8'hFF >> (f % 8)), 1'b1, 1'b1);
            end
            cyc($urandom_range(0, 2));
        end
        drain("rnd_drain");
        rand_rdy = 1'b0;
        cyc(1);
        rx_fifo_tready = 1'b1;
        chk("rnd_drops", 64'(drop_seen - d0), 64'(exp_drops));

        // Reset mid-frame with a committed frame stalled in the buffer
        chk_en = 1'b0;
        rx_fifo_tready = 1'b0;
        send_frame(4, 64'hD00, 8'hFF, 1'b1, 1'b0);
        mac_rx_tvalid = 1'b1;
        mac_rx_tlast  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mac_rx_tdata = 64'hE00 + 64'(i);
            cyc(1);
        end
        mac_rx_tvalid = 1'b0;
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
        @(negedge clk);
        chk("mid_rst_tvalid", 64'(rx_fifo_tvalid), 64'd0);
        chk("mid_rst_tdata", rx_fifo_tdata, 64'd0);
`ifdef XGBE_RX_FIFO_STATS_EN
        chk("stat_good_rst", 64'(rx_good_pkt_cnt), 64'd0);
        chk("stat_bad_rst", 64'(rx_bad_pkt_cnt), 64'd0);
        chk("stat_ovf_rst", 64'(rx_ovf_pkt_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;
        exp_q.delete();
        chk_en = 1'b1;
        rx_fifo_tready = 1'b1;
        o0 = out_cnt;
        send_frame(5, 64'hF00, 8'h1F, 1'b1, 1'b1);
        drain("post_rst_drain");
        chk("post_rst_beats", 64'(out_cnt - o0), 64'd5);
`ifdef XGBE_RX_FIFO_STATS_EN
        chk("stat_good_one", 64'(rx_good_pkt_cnt), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
